rom_port_arbiter: RTL and testbench

//  Shares the single synchronous program-ROM read port (1-cycle registered read) between the

---
 rtl/rom_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares one registered-read program-ROM port between instruction
//            fetch (IF, with two-word burst) and data read (DR). The returned
//            words are routed back to the unit that asked for them.
// Options  : ROM_ARB_RR_EN - round-robin on contention (default: DR > IF)
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_burst,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dr_req,
   input  logic [ADDR_W-1:0] dr_addr,
   output logic              dr_gnt,
   output logic              dr_rvalid,
   output logic [DATA_W-1:0] dr_rdata,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              busy
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   localparam logic c_own_if = 1'b0;
   localparam logic c_own_dr = 1'b1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_rom_addr;
   logic [ADDR_W-1:0] r_burst_addr;
   logic              r_s1_v;
   logic              r_s1_own;
   logic              r_s2_v;
   logic              r_s2_own;
   logic              w_if_gnt;
   logic              w_dr_gnt;
   logic              w_dr_wins;

`ifdef ROM_ARB_RR_EN
   logic r_rr_ptr;

   // Under contention the requester that was not served last wins.
   assign w_dr_wins = (r_rr_ptr == c_own_if);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rr_ptr <= c_own_if;
      end else if (w_dr_gnt) begin
         r_rr_ptr <= c_own_dr;
      end else if (w_if_gnt) begin
         r_rr_ptr <= c_own_if;
      end
   end
`else
   assign w_dr_wins = 1'b1;
`endif

   // Grants only in IDLE; the burst cycle owns the ROM port.
   always_comb begin
      w_if_gnt = 1'b0;
      w_dr_gnt = 1'b0;
      if (rst && (r_state == ST_IDLE)) begin
         if (dr_req && (!if_req || w_dr_wins)) begin
            w_dr_gnt = 1'b1;
         end else if (if_req) begin
            w_if_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_if_gnt && if_burst) w_state_nxt = ST_BURST;
         ST_BURST: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Address register plus a two-stage owner tag that tracks the ROM latency.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_rom_addr   <= '0;
         r_burst_addr <= '0;
         r_s1_v       <= 1'b0;
         r_s1_own     <= c_own_if;
         r_s2_v       <= 1'b0;
         r_s2_own     <= c_own_if;
      end else begin
         r_s2_v   <= r_s1_v;
         r_s2_own <= r_s1_own;
         r_s1_v   <= 1'b0;
         if (r_state == ST_BURST) begin
            r_rom_addr <= r_burst_addr + ADDR_W'(1);
            r_s1_v     <= 1'b1;
            r_s1_own   <= c_own_if;
         end else if (w_dr_gnt) begin
            r_rom_addr <= dr_addr;
            r_s1_v     <= 1'b1;
            r_s1_own   <= c_own_dr;
         end else if (w_if_gnt) begin
            r_rom_addr   <= if_addr;
            r_burst_addr <= if_addr;
            r_s1_v       <= 1'b1;
            r_s1_own     <= c_own_if;
         end
      end
   end

   assign if_gnt    = w_if_gnt;
   assign dr_gnt    = w_dr_gnt;
   assign rom_addr  = r_rom_addr;
   assign if_rvalid = rst & r_s2_v & (r_s2_own == c_own_if);
   assign dr_rvalid = rst & r_s2_v & (r_s2_own == c_own_dr);
   assign if_rdata  = if_rvalid ? rom_data : '0;
   assign dr_rdata  = dr_rvalid ? rom_data : '0;
   assign busy      = r_s1_v | r_s2_v | (r_state == ST_BURST);

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_port_arbiter
// Purpose  : Self-checking bench for rom_port_arbiter with a ROM model and an
//            in-order response scoreboard. Honours ROM_ARB_RR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, if_burst, dr_req;
   logic [15:0] if_addr, dr_addr;
   logic        if_gnt, if_rvalid, dr_gnt, dr_rvalid, busy;
   logic [15:0] if_rdata, dr_rdata, rom_addr;
   logic [15:0] rom_data = 16'h0000;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        own;
      logic [15:0] data;
   } exp_t;

   exp_t sb[$];

   typedef struct {
      bit          dr;
      logic [15:0] addr;
      bit          burst;
      logic [15:0] e1;
      logic [15:0] e2;
   } vec_t;

   vec_t vecs[6];

   rom_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_burst(if_burst),
      .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .dr_req(dr_req), .dr_addr(dr_addr),
      .dr_gnt(dr_gnt), .dr_rvalid(dr_rvalid), .dr_rdata(dr_rdata),
      .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rom_val(input logic [15:0] a);
      case (a)
         16'd0:    return 16'h0000;
         16'd1:    return 16'h1702;
         16'd2:    return 16'h0032;
         16'd50:   return 16'h1234;
         16'hFFFF: return 16'hBEEF;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   always @(posedge clk) rom_data <= rom_val(rom_addr);

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Response monitor: every rvalid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (if_rvalid || dr_rvalid) begin
         if (if_rvalid && dr_rvalid) begin
            check("dual_rvalid", 32'd1, 32'd0);
         end else if (sb.size() == 0) begin
            check("unexpected_rvalid", {15'd0, dr_rvalid, if_rvalid ? if_rdata : dr_rdata}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("resp_owner", {31'd0, dr_rvalid}, {31'd0, e.own});
            check("resp_data", {16'd0, dr_rvalid ? dr_rdata : if_rdata}, {16'd0, e.data});
         end
      end
      if (!if_rvalid && if_rdata !== 16'h0) check("if_rdata_idle", {16'd0, if_rdata}, 32'd0);
      if (!dr_rvalid && dr_rdata !== 16'h0) check("dr_rdata_idle", {16'd0, dr_rdata}, 32'd0);
   end

   // All tasks start and end 1 time unit after a rising edge.
   task automatic do_req(input bit dr, input logic [15:0] addr, input bit burst,
                         input logic [15:0] e1, input logic [15:0] e2);
      bit done = 0;
      if (dr) begin dr_req = 1'b1; dr_addr = addr; end
      else    begin if_req = 1'b1; if_addr = addr; if_burst = burst; end
      for (int i = 0; i < 20 && !done; i++) begin
         #1;
         if ((dr && dr_gnt) || (!dr && if_gnt)) begin
            sb.push_back({dr, e1});
            if (!dr && burst) sb.push_back({1'b0, e2});
            done = 1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("gnt_timeout", 32'd0, 32'd1);
      if_req = 1'b0; if_burst = 1'b0; dr_req = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", sb.size(), 32'd0);
      check("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      bit last_dr;
      bit exp_dr;
      bit seen;

      vecs[0] = '{0, 16'd50,   0, 16'h1234, 16'h0000};
      vecs[1] = '{1, 16'd2,    0, 16'h0032, 16'h0000};
      vecs[2] = '{0, 16'd1,    1, 16'h1702, 16'h0032};
      vecs[3] = '{1, 16'd50,   0, 16'h1234, 16'h0000};
      vecs[4] = '{0, 16'hFFFF, 1, 16'hBEEF, 16'h0000};
      vecs[5] = '{1, 16'd1,    0, 16'h1702, 16'h0000};

      // Reset held with both requests active
      rst = 1'b0; if_req = 1'b1; dr_req = 1'b1; if_burst = 1'b0;
      if_addr = 16'd2; dr_addr = 16'd50;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_gnts", {30'd0, if_gnt, dr_gnt}, 32'd0);
         check("rst_rvalid", {30'd0, if_rvalid, dr_rvalid}, 32'd0);
         check("rst_rom_addr", {16'd0, rom_addr}, 32'd0);
         check("rst_busy", {31'd0, busy}, 32'd0);
      end
      rst = 1'b1; if_req = 1'b0; dr_req = 1'b0;
      @(posedge clk); #1;

      // IF single read: exact latency
      if_req = 1'b1; if_addr = 16'd50;
      #1 check("if_gnt_alone", {31'd0, if_gnt}, 32'd1);
      sb.push_back({1'b0, 16'h1234});
      @(posedge clk); #1;
      if_req = 1'b0;
      check("single_rvalid_early", {31'd0, if_rvalid}, 32'd0);
      check("single_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      check("single_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      check("single_if_rdata", {16'd0, if_rdata}, 32'h1234);
      check("single_dr_rvalid", {31'd0, dr_rvalid}, 32'd0);
      drain();

      // IF burst with DR request arriving during BURST
      if_req = 1'b1; if_addr = 16'd1; if_burst = 1'b1;
      sb.push_back({1'b0, 16'h1702});
      sb.push_back({1'b0, 16'h0032});
      @(posedge clk); #1;
      if_req = 1'b0; if_burst = 1'b0;
      dr_req = 1'b1; dr_addr = 16'd50;
      #1 check("burst_dr_gnt_blocked", {30'd0, if_gnt, dr_gnt}, 32'd0);
      @(posedge clk); #1;
      check("burst_w1", {15'd0, if_rvalid, if_rdata}, {16'd1, 16'h1702});
      #1 check("burst_dr_gnt_after", {31'd0, dr_gnt}, 32'd1);
      sb.push_back({1'b1, 16'h1234});
      @(posedge clk); #1;
      dr_req = 1'b0;
      check("burst_w2", {15'd0, if_rvalid, if_rdata}, {16'd1, 16'h0032});
      drain();

      // Table-driven back-to-back requests
      foreach (vecs[i]) do_req(vecs[i].dr, vecs[i].addr, vecs[i].burst, vecs[i].e1, vecs[i].e2);
      drain();

      // Wrap of the burst address
      if_req = 1'b1; if_addr = 16'hFFFF; if_burst = 1'b1;
      sb.push_back({1'b0, 16'hBEEF});
      sb.push_back({1'b0, 16'h0000});
      @(posedge clk); #1;
      if_req = 1'b0; if_burst = 1'b0;
      check("wrap_addr1", {16'd0, rom_addr}, 32'h0000FFFF);
      @(posedge clk); #1;
      check("wrap_addr2", {16'd0, rom_addr}, 32'h00000000);
      drain();

      // Continuous contention from a fresh reset
      pulse_reset();
      last_dr = 1'b0;
      if_req = 1'b1; if_addr = 16'd2; dr_req = 1'b1; dr_addr = 16'd50;
      for (int i = 0; i < 6; i++) begin
`ifdef ROM_ARB_RR_EN
         exp_dr = !last_dr;
`else
         exp_dr = 1'b1;
`endif
         #1 check("contention_gnts", {30'd0, if_gnt, dr_gnt}, {30'd0, !exp_dr, exp_dr});
         sb.push_back({exp_dr, exp_dr ? 16'h1234 : 16'h0032});
         last_dr = exp_dr;
         @(posedge clk); #1;
      end
      if_req = 1'b0; dr_req = 1'b0;
      drain();

      // Reset while a DR read is in flight
      dr_req = 1'b1; dr_addr = 16'd2;
      #1 check("midrst_gnt", {31'd0, dr_gnt}, 32'd1);
      @(posedge clk); #1;
      dr_req = 1'b0; rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         if (dr_rvalid) seen = 1'b1;
      end
      rst = 1'b1;
      check("midrst_rom_addr", {16'd0, rom_addr}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (dr_rvalid) seen = 1'b1;
      end
      check("midrst_no_rvalid", {31'd0, seen}, 32'd0);
      do_req(1'b1, 16'd1, 1'b0, 16'h1702, 16'h0000);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
